// File: rtl/fpa_zp_unload.sv
// rtl/fpa_zp_unload.sv - ZP bus unload sequencer: steers F-PA ZP selects and streams captured words
module fpa_zp_unload (
    input  logic        clk_sys,
    input  logic        clr_,
    input  logic        start,
    input  logic [1:0]  fmt,
    input  logic        with_flags,
    input  logic        abort,
    input  logic [0:15] zp,
    output logic        zpa,
    output logic        zpb,
    output logic        _0_zp,
    output logic [0:15] out_w,
    output logic [1:0]  out_sel,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEL  = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state, state_d;
    logic [1:0]  fmt_q;
    logic        wf_q;
    logic [1:0]  idx, idx_d;
    logic [1:0]  sel_q, sel_d;
    logic        zero_d;
    logic        latch, capture, drop;
    logic        is_last;
    logic [2:0]  n_start;

    // Data words use their own index as select code; anything past fmt is the flags word.
    function automatic logic [1:0] word_code(input logic [1:0] i, input logic [1:0] f);
        return (i < f) ? i : 2'b11;
    endfunction

    assign sel_q   = {zpb, zpa};
    assign n_start = {1'b0, fmt} + {2'b00, with_flags};
    assign is_last = (({1'b0, idx} + 3'd1) == ({1'b0, fmt_q} + {2'b00, wf_q}));
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);

    always_comb begin
        state_d = state;
        idx_d   = idx;
        sel_d   = sel_q;
        zero_d  = _0_zp;
        latch   = 1'b0;
        capture = 1'b0;
        drop    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    latch = 1'b1;
                    idx_d = 2'd0;
                    if (n_start == 3'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SEL;
                        sel_d   = word_code(2'd0, fmt);
                        zero_d  = 1'b0;
                    end
                end
            end
            S_SEL: begin
                if (abort) begin
                    state_d = S_IDLE;
                    sel_d   = 2'b00;
                    zero_d  = 1'b1;
                    drop    = 1'b1;
                end else begin
                    capture = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (abort) begin
                    state_d = S_IDLE;
                    sel_d   = 2'b00;
                    zero_d  = 1'b1;
                    drop    = 1'b1;
                end else if (out_valid && out_ready) begin
                    drop = 1'b1;
                    if (out_last) begin
                        state_d = S_DONE;
                        sel_d   = 2'b00;
                        zero_d  = 1'b1;
                    end else begin
                        state_d = S_SEL;
                        idx_d   = idx + 2'd1;
                        sel_d   = word_code(idx + 2'd1, fmt_q);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                sel_d   = 2'b00;
                zero_d  = 1'b1;
                drop    = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                sel_d   = 2'b00;
                zero_d  = 1'b1;
                drop    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge clr_) begin
        if (!clr_) begin
            state     <= S_IDLE;
            idx       <= 2'd0;
            fmt_q     <= 2'd0;
            wf_q      <= 1'b0;
            zpa       <= 1'b0;
            zpb       <= 1'b0;
            _0_zp     <= 1'b1;
            out_w     <= '0;
            out_sel   <= 2'b00;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
            {zpb, zpa} <= sel_d;
            _0_zp <= zero_d;
            if (latch) begin
                fmt_q <= fmt;
                wf_q  <= with_flags;
            end
            if (capture) begin
                out_w     <= zp;
                out_sel   <= sel_q;
                out_valid <= 1'b1;
                out_last  <= is_last;
            end
            if (drop) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/fpa_zp_unload.md
# fpa_zp_unload

Sequencer that unloads an FPU result from the F-PA unit over its 16-bit ZP bus. It steers the ZP source selects (`zpa`, `zpb`, `_0_zp`), captures each selected word, and presents the words one at a time on a valid/ready output towards the register/memory write path. It is the reading end of the ZP bus: the F-PA drives ZP combinationally from T, D and the flag inputs, and this block decides which word is on the bus and when it is taken.

## Interface

Parameters: none.

- `clk_sys` input 1: system clock; all state changes on rising edge.
- `clr_` input 1: reset, asynchronous, active-low.
- `start` input 1: one-cycle request to begin an unload; sampled only in IDLE.
- `fmt` input 2: number of data words. 0: none. 1: T[0:15]. 2: adds T[16:31]. 3: adds {T[32:39], D[0:7]}.
- `with_flags` input 1: append the flags word {Z,M,V,C,12'b0} after the data words.
- `abort` input 1: cancel the unload in progress.
- `zp` input [0:15]: ZP bus from F-PA.
- `zpa`, `zpb` output 1 each: ZP source select to F-PA. {zpb,zpa}: 00 = T[0:15], 01 = T[16:31], 10 = T[32:39]+D, 11 = flags.
- `_0_zp` output 1: forces ZP to zero while high.
- `out_w` output [0:15]: captured word.
- `out_sel` output 2: {zpb,zpa} code the current `out_w` was captured with.
- `out_valid` output 1: `out_w` holds a word not yet accepted.
- `out_ready` input 1: consumer accepts the word when `out_valid && out_ready`.
- `out_last` output 1: the current word is the final word of the unload.
- `busy` output 1: the block is not in IDLE.
- `done` output 1: one-cycle pulse when an unload completes normally.

## Operation

- On `start` in IDLE, the block latches `fmt` and `with_flags` and builds the word count N = fmt + with_flags (range 0..4). Selects are issued in the order 00, 01, 10, 11, skipping codes that were not requested.
- States:
  - IDLE: `_0_zp`=1, selects 00, `busy`=0.
    - `start` with N=0 → DONE.
    - `start` with N>0 → SEL.
  - SEL: drives the select code for word index i and sets `_0_zp`=0. On the clock edge, `out_w`←`zp`, `out_sel`←code, `out_valid`←1, and `out_last`←(i==N-1). Next state: HOLD.
  - HOLD: selects and `_0_zp` stay as they were in SEL.
    - Accept with `out_last`=0 → i+1, `out_valid`←0, next SEL.
    - Accept with `out_last`=1 → `out_valid`←0, next DONE.
    - No accept → stay in HOLD; `out_w`, `out_sel` and `out_last` do not change.
  - DONE: `done`=1 for one cycle, `_0_zp`←1, next IDLE.
- `start` while `busy` is ignored. `fmt` and `with_flags` changes after the latch have no effect.
- `abort` in SEL, HOLD or DONE: the next state is IDLE. `out_valid`, `out_last` and `done` are 0 from the next cycle, and `_0_zp`=1.
  - `abort` and a HOLD accept in the same cycle: abort wins. The word counts as taken, but no `done` is issued.
  - `abort` in IDLE has no effect. `abort` and `start` together in IDLE: `start` is ignored.
- The word index is 2 bits and never wraps, because N≤4. The 11 code is used only when `with_flags` is set.

## Timing

- Reset values: `zpa`=0, `zpb`=0, `_0_zp`=1, `out_w`=0, `out_sel`=0, `out_valid`=0, `out_last`=0, `busy`=0, `done`=0, state IDLE. Asserting `clr_` mid-unload forces these values immediately; no partial word remains.
- Selects are registered outputs. ZP settles combinationally within the SEL cycle and is sampled at the end of that cycle.
- Start to first `out_valid`: 2 cycles (start edge → SEL, SEL edge → valid).
- With `out_ready` held high: one word every 2 cycles. An N-word unload finishes with `done` at cycle 2N+1 after `start`, and `busy` drops the cycle after that.
- N=0: `done` one cycle after `start`.
- `busy`=1 in SEL, HOLD and DONE.

## Test plan

- Reset, then `clr_` high → every output at its reset value; `_0_zp`=1.
- Three data words (T=40'h12_3456_789A, D=8'hBC, `fmt`=3, `with_flags`=0, `out_ready`=1):
  - Words 16'h1234, 16'h5678, 16'h9ABC with `out_sel` 00, 01, 10.
  - `out_last` set only on the third word.
  - `done` 7 cycles after `start`.
- `fmt`=1, `with_flags`=1, Z=1, C=1:
  - Words T[0:15], then 16'h9000 with `out_sel`=11.
  - `out_ready` held low for 5 cycles on word 1: `out_w` stable, selects unchanged, `out_valid` stays 1.
- `fmt`=0, `with_flags`=0 → `done` at start+1; `out_valid` never asserted; `_0_zp` stays 1.
- `abort` in HOLD of word 2 (`fmt`=3), and separately `clr_` low in SEL:
  - Next cycle (or immediately, for `clr_`): IDLE, `out_valid`=0, no `done`.
  - A new `start` afterwards completes normally.
- `start` pulsed during HOLD with a different `fmt` → ignored; the original word count is delivered.
